// File: rtl/fp_fdiv_seq_pkg.sv
// fp_fdiv_seq shared types: rounder input record, latched operation record,
// FSM state codes and per-format constants.
package fp_fdiv_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SPEC   = 3'd1;
    localparam state_t ST_DIV    = 3'd2;
    localparam state_t ST_NORM   = 3'd3;
    localparam state_t ST_DENORM = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    // operand class bit positions in {snan, qnan, inf, zero}
    localparam int CLS_SNAN = 3;
    localparam int CLS_QNAN = 2;
    localparam int CLS_INF  = 1;
    localparam int CLS_ZERO = 0;

    localparam logic [13:0] BIAS_S  = 14'd127;
    localparam logic [13:0] BIAS_D  = 14'd1023;
    localparam logic [6:0]  ITERS_S = 7'd27;
    localparam logic [6:0]  ITERS_D = 7'd56;

    typedef struct packed {
        logic        sig;
        logic [13:0] expo;
        logic [53:0] mant;
        logic [1:0]  rema;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [2:0]  grs;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
    } fp_rnd_in_type;

    // Latched operation; the dividend significand goes straight
    // into the remainder register and is not kept here.
    typedef struct packed {
        logic        a_sig;
        logic        b_sig;
        logic [13:0] a_expo;
        logic [13:0] b_expo;
        logic [52:0] b_mant;
        logic [3:0]  a_cls;
        logic [3:0]  b_cls;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } fp_fdiv_seq_in_type;

    function automatic logic [13:0] fdiv_bias(input logic [1:0] fmt);
        return (fmt == 2'd1) ? BIAS_D : BIAS_S;
    endfunction

    function automatic logic [6:0] fdiv_iters(input logic [1:0] fmt);
        return (fmt == 2'd1) ? ITERS_D : ITERS_S;
    endfunction

endpackage

// File: rtl/fp_fdiv_seq_if.sv
// fp_fdiv_seq handshake interface: operand offer on the input side,
// rounder record on the output side.
interface fp_fdiv_seq_if
    import fp_fdiv_seq_pkg::*;
();
    logic          in_valid;
    logic          in_ready;
    logic          a_sig;
    logic          b_sig;
    logic [13:0]   a_expo;
    logic [13:0]   b_expo;
    logic [52:0]   a_mant;
    logic [52:0]   b_mant;
    logic [3:0]    a_cls;
    logic [3:0]    b_cls;
    logic [1:0]    fmt;
    logic [2:0]    rm;
    logic          out_valid;
    logic          out_ready;
    fp_rnd_in_type out;

    modport master (
        output in_valid, a_sig, b_sig, a_expo, b_expo,
        output a_mant, b_mant, a_cls, b_cls, fmt, rm, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, a_sig, b_sig, a_expo, b_expo,
        input  a_mant, b_mant, a_cls, b_cls, fmt, rm, out_ready,
        output in_ready, out_valid, out
    );

endinterface

// File: rtl/fp_fdiv_step.sv
// fp_fdiv_step: one restoring subtract/compare iteration.
// Produces the quotient bit and the shifted partial remainder.
module fp_fdiv_step (
    input  logic [54:0] rem,
    input  logic [52:0] div,
    output logic        q_bit,
    output logic [54:0] rem_next
);

    logic [55:0] trial;

    // trial subtract, keep it when non-negative, then shift
    always_comb begin
        trial    = {1'b0, rem} - {3'b000, div};
        q_bit    = ~trial[55];
        rem_next = (q_bit ? trial[54:0] : rem) << 1;
    end

endmodule

// File: rtl/fp_fdiv_seq.sv
// fp_fdiv_seq: iterative radix-2 restoring divider feeding the rounder.
// Produces an unrounded, already denormalized quotient record.
module fp_fdiv_seq
    import fp_fdiv_seq_pkg::*;
#(
    parameter int MAXSHIFT = 56
) (
    input logic          clock,
    input logic          reset,
    fp_fdiv_seq_if.slave bus
);

    state_t             state;
    fp_fdiv_seq_in_type in_rec;
    fp_fdiv_seq_in_type op;
    logic [54:0]        rem;
    logic [55:0]        quo;
    logic [6:0]         cnt;
    fp_rnd_in_type      res;

    logic               q_bit;
    logic [54:0]        rem_next;

    fp_rnd_in_type      spec_res;
    fp_rnd_in_type      norm_res;
    logic               dbl;
    logic [13:0]        e_base;
    logic [13:0]        e_norm;
    logic [55:0]        q_al;
    logic [54:0]        q_sh;
    logic               e_tiny;
    logic [14:0]        sh_full;
    logic [6:0]         sh_cnt;

    fp_fdiv_step u_step (
        .rem      (rem),
        .div      (op.b_mant),
        .q_bit    (q_bit),
        .rem_next (rem_next)
    );

    assign in_rec = '{
        a_sig:  bus.a_sig,
        b_sig:  bus.b_sig,
        a_expo: bus.a_expo,
        b_expo: bus.b_expo,
        b_mant: bus.b_mant,
        a_cls:  bus.a_cls,
        b_cls:  bus.b_cls,
        fmt:    bus.fmt,
        rm:     bus.rm
    };

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out       = res;

    // special-operand result, first matching rule wins
    always_comb begin
        spec_res     = '0;
        spec_res.sig = op.a_sig ^ op.b_sig;
        spec_res.fmt = op.fmt;
        spec_res.rm  = op.rm;
        if (op.a_cls[CLS_SNAN] | op.b_cls[CLS_SNAN] |
            (op.a_cls[CLS_ZERO] & op.b_cls[CLS_ZERO]) |
            (op.a_cls[CLS_INF] & op.b_cls[CLS_INF]))
            spec_res.snan = 1'b1;
        else if (op.a_cls[CLS_QNAN] | op.b_cls[CLS_QNAN])
            spec_res.qnan = 1'b1;
        else if (op.a_cls[CLS_INF])
            spec_res.inf = 1'b1;
        else if (op.b_cls[CLS_ZERO])
            spec_res.dbz = 1'b1;
        else if (op.a_cls[CLS_ZERO] | op.b_cls[CLS_INF])
            spec_res.zero = 1'b1;
    end

    // normalize quotient, split into hidden+fraction, guard, round
    always_comb begin
        dbl    = (op.fmt == 2'd1);
        e_base = op.a_expo - op.b_expo + fdiv_bias(op.fmt);
        q_al   = dbl ? quo : {quo[26:0], 29'd0};
        q_sh   = q_al[55] ? q_al[55:1] : q_al[54:0];
        e_norm = q_al[55] ? e_base : e_base - 14'd1;

        norm_res      = '0;
        norm_res.sig  = op.a_sig ^ op.b_sig;
        norm_res.fmt  = op.fmt;
        norm_res.rm   = op.rm;
        norm_res.expo = e_norm;
        norm_res.rema = {1'b0, |rem};
        if (dbl) begin
            norm_res.mant = {1'b0, q_sh[54:2]};
            norm_res.grs  = {q_sh[1], q_sh[0], 1'b0};
        end else begin
            norm_res.mant = {30'd0, q_sh[54:31]};
            norm_res.grs  = {q_sh[30], q_sh[29], 1'b0};
        end

        e_tiny  = e_norm[13] | (e_norm == 14'd0);
        sh_full = 15'd1 - {e_norm[13], e_norm};
        sh_cnt  = (sh_full > 15'(MAXSHIFT)) ? 7'(MAXSHIFT)
                                           : sh_full[6:0];
    end

    // operation sequencer and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            op    <= '0;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            res   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op    <= in_rec;
                        rem   <= {2'b00, bus.a_mant};
                        quo   <= '0;
                        cnt   <= fdiv_iters(bus.fmt);
                        state <= (|{bus.a_cls, bus.b_cls}) ? ST_SPEC
                                                           : ST_DIV;
                    end
                end
                ST_SPEC: begin
                    res   <= spec_res;
                    state <= ST_DONE;
                end
                ST_DIV: begin
                    rem <= rem_next;
                    quo <= {quo[54:0], q_bit};
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1)
                        state <= ST_NORM;
                end
                ST_NORM: begin
                    res <= norm_res;
                    if (e_tiny) begin
                        cnt   <= sh_cnt;
                        state <= ST_DENORM;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DENORM: begin
                    res.mant <= res.mant >> 1;
                    res.grs  <= {res.mant[0], res.grs[2],
                                 res.grs[1] | res.grs[0]};
                    cnt      <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        res.expo <= '0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
